// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target peripheral: fill byte, register address
// codes, status bit layout and the select-state encoding.
package spi_target_pkg;

  localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

  localparam logic [3:0] PERI_SPI_TARGET_DATA   = 4'hC;
  localparam logic [3:0] PERI_SPI_TARGET_STATUS = 4'hD;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_BUSY     = 3;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_SELECTED = 1'b1
  } state_e;

  // Packs the flags into the status register byte seen by the CPU.
  function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_valid,
                                             input logic overrun, input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[ST_TX_FULL]  = tx_full;
    s[ST_RX_VALID] = rx_valid;
    s[ST_OVERRUN]  = overrun;
    s[ST_BUSY]     = busy;
    return s;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// N-stage synchroniser for an asynchronous pin, with a selectable reset level.
// STAGES must be 2 or 3.
module pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames. All pins are oversampled in the
// clk domain; SCK/CS_n edges are detected after synchronisation.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] data_in,
  input  logic       tx_load,
  output logic       tx_full,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       overrun,
  input  logic       clear_overrun,
  output logic       busy
);

  localparam int NUM_PINS = 3;
  // Pin order {mosi, cs_n, sck}; cs_n idles high so reset never looks like a select.
  localparam logic [NUM_PINS-1:0] PIN_RST = 3'b010;

  logic [NUM_PINS-1:0] pin_raw, pin_s;
  logic                sck_s, cs_s, mosi_s;
  logic                sck_d, cs_d;
  logic                sck_rise, sck_fall, cs_fall, cs_rise;

  assign pin_raw = {spi_mosi, spi_cs_n, spi_sck};

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(PIN_RST[g])) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pin_raw[g]),
      .q   (pin_s[g])
    );
  end

  assign sck_s  = pin_s[0];
  assign cs_s   = pin_s[1];
  assign mosi_s = pin_s[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, tx_hold;
  logic       load_tx, tx_step, rx_step, deselect, select, byte_done, accept;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Deselection is checked first so it wins over a coincident SCK edge.
  always_comb begin
    state_d  = state_q;
    load_tx  = 1'b0;
    tx_step  = 1'b0;
    rx_step  = 1'b0;
    deselect = 1'b0;
    select   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_SELECTED;
          select  = 1'b1;
          load_tx = 1'b1;
        end
      end
      S_SELECTED: begin
        if (cs_rise) begin
          state_d  = S_IDLE;
          deselect = 1'b1;
        end else begin
          rx_step = sck_rise;
          if (sck_fall) begin
            if (bit_cnt == 3'd0) load_tx = 1'b1;
            else                 tx_step = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_byte   = {rx_shift[6:0], mosi_s};
  assign byte_done = rx_step && (bit_cnt == 3'd7);
  assign accept    = byte_done && (!rx_valid || rx_read);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (deselect || select) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
    end else if (rx_step) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tx_shift <= 8'h00;
    else if (load_tx) tx_shift <= tx_full ? tx_hold : FILL_BYTE;
    else if (tx_step) tx_shift <= {tx_shift[6:0], 1'b0};
  end

  // A CPU write in the same cycle as a boundary load stays pending: the
  // shifter already took the old value (or FILL_BYTE) above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold <= 8'h00;
      tx_full <= 1'b0;
    end else if (tx_load) begin
      tx_hold <= data_in;
      tx_full <= 1'b1;
    end else if (load_tx) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= 8'h00;
      rx_valid <= 1'b0;
    end else if (accept) begin
      data_out <= rx_byte;
      rx_valid <= 1'b1;
    end else if (rx_read) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overrun <= 1'b0;
    else if (byte_done && !accept) overrun <= 1'b1;
    else if (clear_overrun)        overrun <= 1'b0;
  end

  assign busy        = (state_q == S_SELECTED);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy ? tx_shift[7] : 1'b1;

endmodule
